// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-control bundle between the EX/D stage decode signals and the stall/flush controller.
// The controller consumes hazard inputs and returns pipeline-register enables plus perf counters.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             MemReadE;
    logic [4:0]       RD_E;
    logic [4:0]       Rs1_D;
    logic [4:0]       Rs2_D;
    logic             PCSrcE;
    logic             MdStartE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             MdDone;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output MemReadE, RD_E, Rs1_D, Rs2_D, PCSrcE, MdStartE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM, MdDone,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  MemReadE, RD_E, Rs1_D, Rs2_D, PCSrcE, MdStartE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM, MdDone,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, taken-branch flushes,
// multi-cycle MUL/DIV occupancy of EX, and saturating stall/flush cycle counters.
module pipeline_stall_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_stall_ctrl_if.slave  bus
);
    typedef enum logic {RUN, MD_BUSY} state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic md_done;
    } ctrl_t;

    state_e           state_q, state_d;
    logic [4:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lw_stall;
    ctrl_t            ctrl;

    assign lw_stall = bus.MemReadE && (bus.RD_E != 5'd0) &&
                      ((bus.RD_E == bus.Rs1_D) || (bus.RD_E == bus.Rs2_D));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        ctrl     = '0;
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            RUN: begin
                if (bus.PCSrcE) begin
                    ctrl.flush_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                end else if (bus.MdStartE) begin
                    ctrl.stall_f = 1'b1;
                    ctrl.stall_d = 1'b1;
                    ctrl.stall_e = 1'b1;
                    ctrl.flush_m = 1'b1;
                    md_cnt_d     = 5'(MD_LATENCY - 2);
                    state_d      = MD_BUSY;
                end else if (lw_stall) begin
                    ctrl.stall_f = 1'b1;
                    ctrl.stall_d = 1'b1;
                    ctrl.flush_e = 1'b1;
                end
            end
            MD_BUSY: begin
                // Branch and load hazards cannot arise while EX is held by the MUL/DIV.
                if (md_cnt_q != 5'd0) begin
                    ctrl.stall_f = 1'b1;
                    ctrl.stall_d = 1'b1;
                    ctrl.stall_e = 1'b1;
                    ctrl.flush_m = 1'b1;
                    md_cnt_d     = md_cnt_q - 5'd1;
                end else begin
                    ctrl.md_done = 1'b1;
                    state_d      = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (!rst) begin
            ctrl = '0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ctrl.stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if ((ctrl.flush_d || ctrl.flush_e) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            md_cnt_q    <= 5'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.StallF    = ctrl.stall_f;
    assign bus.StallD    = ctrl.stall_d;
    assign bus.StallE    = ctrl.stall_e;
    assign bus.FlushD    = ctrl.flush_d;
    assign bus.FlushE    = ctrl.flush_e;
    assign bus.FlushM    = ctrl.flush_m;
    assign bus.MdDone    = ctrl.md_done;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed hazard scenarios then random traffic, each cycle
// compared against a cycle-indexed behavioural model of the stall/flush rules.
module tb_pipeline_stall_ctrl;
    localparam int MD_LATENCY = 4;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    // Control vector order: {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdDone}
    localparam logic [6:0] C_NONE = 7'b000_0000;
    localparam logic [6:0] C_MD   = 7'b111_0010;
    localparam logic [6:0] C_BR   = 7'b000_1100;
    localparam logic [6:0] C_LW   = 7'b110_0100;
    localparam logic [6:0] C_DONE = 7'b000_0001;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_stall_ctrl #(
        .MD_LATENCY(MD_LATENCY),
        .CNT_W     (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: a MUL/DIV issued at cycle t owns EX until its MdDone cycle t+MD_LATENCY-1.
    int cyc       = 0;
    bit md_active = 1'b0;
    int done_at   = 0;
    int n_stall   = 0;
    int n_flush   = 0;

    function automatic int sat(input int n);
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic mem, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic pc, input logic md, input string tag);
        logic [6:0] exp_ctl;
        logic [6:0] got_ctl;
        bit         lw;
        @(negedge clk);
        rst          = r;
        bus.MemReadE = mem;
        bus.RD_E     = rd;
        bus.Rs1_D    = rs1;
        bus.Rs2_D    = rs2;
        bus.PCSrcE   = pc;
        bus.MdStartE = md;
        #1;
        lw      = mem && (rd != 0) && (rd == rs1 || rd == rs2);
        exp_ctl = C_NONE;
        if (!r) begin
            md_active = 1'b0;
            n_stall   = 0;
            n_flush   = 0;
        end else if (md_active) begin
            if (cyc < done_at) begin
                exp_ctl = C_MD;
            end else begin
                exp_ctl   = C_DONE;
                md_active = 1'b0;
            end
        end else if (pc) begin
            exp_ctl = C_BR;
        end else if (md) begin
            exp_ctl   = C_MD;
            md_active = 1'b1;
            done_at   = cyc + MD_LATENCY - 1;
        end else if (lw) begin
            exp_ctl = C_LW;
        end
        got_ctl = {bus.StallF, bus.StallD, bus.StallE, bus.FlushD, bus.FlushE,
                   bus.FlushM, bus.MdDone};
        check({tag, ":ctl"}, 32'(got_ctl), 32'(exp_ctl));
        check({tag, ":stall_cnt"}, 32'(bus.stall_cnt), 32'(sat(n_stall)));
        check({tag, ":flush_cnt"}, 32'(bus.flush_cnt), 32'(sat(n_flush)));
        if (r) begin
            n_stall += int'(exp_ctl[6]);
            n_flush += int'(exp_ctl[3] | exp_ctl[2]);
        end
        cyc++;
    endtask

    initial begin
        bus.MemReadE = 1'b0;
        bus.RD_E     = 5'd0;
        bus.Rs1_D    = 5'd0;
        bus.Rs2_D    = 5'd0;
        bus.PCSrcE   = 1'b0;
        bus.MdStartE = 1'b0;

        // Reset held with every hazard input active
        step(0, 1, 5'd7, 5'd7, 5'd7, 1, 1, "rst_hold0");
        step(0, 1, 5'd7, 5'd7, 5'd7, 1, 1, "rst_hold1");
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "rst_release");

        // Load-use: one bubble, then the load has moved on
        step(1, 1, 5'd5, 5'd1, 5'd5, 0, 0, "lw_rs2");
        step(1, 0, 5'd0, 5'd1, 5'd5, 0, 0, "lw_after");
        step(1, 1, 5'd0, 5'd0, 5'd3, 0, 0, "lw_x0");
        step(1, 1, 5'd9, 5'd9, 5'd2, 0, 0, "lw_rs1");
        step(1, 1, 5'd9, 5'd8, 5'd2, 0, 0, "lw_nomatch");

        // MUL/DIV occupancy with a taken branch ignored mid-sequence
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, "md_issue");
        step(1, 0, 5'd0, 5'd0, 5'd0, 1, 0, "md_busy_br");
        step(1, 1, 5'd4, 5'd4, 5'd0, 0, 0, "md_busy_lw");
        step(1, 0, 5'd0, 5'd0, 5'd0, 1, 1, "md_done");
        // Back-to-back MUL/DIV right after MdDone
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, "md2_issue");
        for (int i = 0; i < MD_LATENCY; i++) begin
            step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "md2_run");
        end

        // Branch beats MUL/DIV and load-use in the same cycle
        step(1, 1, 5'd6, 5'd6, 5'd6, 1, 1, "prio");
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "prio_after");

        // Reset pulse in the second MD_BUSY cycle aborts without MdDone
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, "abort_issue");
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "abort_busy1");
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "abort_rst");
        for (int i = 0; i < MD_LATENCY; i++) begin
            step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "abort_after");
        end

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 5'd3, 5'd3, 5'd0, 0, 0, "sat_lw");
        end
        step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "sat_hold");
        step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "sat_clear");

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 63) != 0),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 6) == 0),
                 "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It sits beside the forwarding unit and resolves the hazards forwarding cannot cover: load-use stalls, taken-branch flushes and multi-cycle MUL/DIV occupancy of EX. It produces the stall/flush enables for the F/D, D/E and E/M pipeline registers and keeps saturating performance counters for stall and flush cycles.

## Interface
- MD_LATENCY, 4, total EX-stage cycles occupied by a MUL/DIV instruction; legal range 2..32
- CNT_W, 32, width of each performance counter
- clk  input  1  core clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- MemReadE  input  1  instruction in EX is a load
- RD_E  input  5  destination register of EX instruction
- Rs1_D  input  5  source 1 of D instruction
- Rs2_D  input  5  source 2 of D instruction
- PCSrcE  input  1  branch/jump in EX is taken
- MdStartE  input  1  instruction in EX is MUL/DIV
- StallF  output  1  hold PC
- StallD  output  1  hold F/D register
- StallE  output  1  hold D/E register
- FlushD  output  1  clear F/D register (bubble)
- FlushE  output  1  clear D/E register (bubble)
- FlushM  output  1  clear E/M register (bubble)
- MdDone  output  1  one-cycle pulse, MUL/DIV result valid in EX this cycle
- stall_cnt  output  CNT_W  cycles with StallF=1, saturating
- flush_cnt  output  CNT_W  cycles with FlushD=1 or FlushE=1, saturating

## Operation
- Two-state FSM: RUN, MD_BUSY; 5-bit down-counter md_cnt.
- lwStall = MemReadE & (RD_E != 0) & (RD_E == Rs1_D | RD_E == Rs2_D).
- RUN, priority high to low:
  - PCSrcE=1: FlushD=1, FlushE=1; no stall; stay RUN. Takes precedence over lwStall and MdStartE (the wrong-path instruction in D is discarded).
  - MdStartE=1: StallF=StallD=StallE=1, FlushM=1; md_cnt <= MD_LATENCY-2; next MD_BUSY.
  - lwStall=1: StallF=StallD=1, FlushE=1; stay RUN (one bubble; forwarding covers the rest).
  - else all control outputs 0.
- MD_BUSY:
  - md_cnt != 0: StallF=StallD=StallE=1, FlushM=1; md_cnt decrements.
  - md_cnt == 0: MdDone=1, all stalls/flushes 0; next RUN.
  - PCSrcE, MemReadE and lwStall are ignored.
- Counters:
  - stall_cnt increments on every cycle with StallF=1.
  - flush_cnt increments on every cycle with FlushD|FlushE=1. The lwStall bubble counts toward both.
  - Both saturate at 2^CNT_W-1 and never wrap.
- While rst=0, all control outputs are forced to 0 combinationally, independent of the inputs.

## Timing
- Reset: state=RUN, md_cnt=0, stall_cnt=0, flush_cnt=0. All outputs read 0 while rst=0.
- Stall, flush and MdDone outputs are combinational from the inputs and current state, and are valid in the same cycle as the triggering input.
- MUL/DIV issue at cycle t:
  - Stalls asserted in cycles t..t+MD_LATENCY-2.
  - MdDone asserted in cycle t+MD_LATENCY-1.
  - EX occupancy is exactly MD_LATENCY cycles.
  - A new instruction enters EX at t+MD_LATENCY.
- Back-to-back MUL/DIV: a second MdStartE in the cycle after MdDone starts a new sequence with no gap.
- Load-use costs exactly one bubble. The cycle after the stall, the load is in MEM, lwStall is 0 and the stall does not repeat.
- Reset asserted mid-MD_BUSY: the FSM aborts to RUN immediately and the counters clear. No MdDone pulse is emitted.
- Counter update is registered: the value is visible one cycle after the counted cycle.

## Test plan
- Reset: hold rst=0 with MdStartE=1 and PCSrcE=1 → all outputs 0 and both counters 0. Release rst → RUN state, outputs follow the inputs.
- Load-use: MemReadE=1, RD_E=5, Rs2_D=5 → StallF=StallD=FlushE=1 for 1 cycle, stall_cnt=1, flush_cnt=1. With RD_E=0 and Rs1_D=0 → no stall.
- MUL/DIV with MD_LATENCY=4, MdStartE=1 at cycle 10 → Stall{F,D,E}=FlushM=1 in cycles 10–12, MdDone=1 at cycle 13, stall_cnt=3.
- Priority: PCSrcE=1 with lwStall=1 and MdStartE=1 in the same cycle → only FlushD=FlushE=1, state stays RUN. PCSrcE=1 during MD_BUSY → ignored.
- Abort: rst=0 pulse in the second MD_BUSY cycle → no MdDone, state RUN, counters 0.
- Saturation: CNT_W=4, 20 consecutive load-use cycles → stall_cnt holds at 15.
